issue_stage: RTL and testbench

ISSUE_STAGE -- requirements
Module: issue_stage

---
 rtl/register_file_params.sv | 13 +
 rtl/issue_stage.sv | 128 ++++++++++++
 tb/tb_issue_stage.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_params.sv
// Shared register-file geometry and the issue-stage output-register state type.
package register_file_params;

  localparam int REGISTER_SIZE             = 32;
  localparam int REGISTER_DESCRIPTOR_WIDTH = $clog2(REGISTER_SIZE);
  localparam int OPERAND_WIDTH             = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } issue_state_t;

endpackage

// File: rtl/issue_stage.sv
// Issue stage: reads operands, reserves destinations and hands instructions to execute.
// Optional perf counters are enabled by defining ISSUE_STAGE_PERF_COUNTER_EN.
module issue_stage
  import register_file_params::*;
#(
  parameter int OPCODE_WIDTH = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [OPCODE_WIDTH-1:0]              in_opcode,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] in_src0,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] in_src1,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] in_dest,
  input  logic                                 in_writes,
  output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rf_operand0,
  output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rf_operand1,
  input  logic [OPERAND_WIDTH-1:0]             rf_value0,
  input  logic [OPERAND_WIDTH-1:0]             rf_value1,
  input  logic                                 rf_reserved,
  output logic                                 rf_write_reserve,
  output logic                                 rf_write_back,
  output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rf_register,
  output logic [OPERAND_WIDTH-1:0]             rf_result,
  input  logic                                 wb_valid,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] wb_register,
  input  logic [OPERAND_WIDTH-1:0]             wb_result,
  output logic                                 ex_valid,
  input  logic                                 ex_ready,
  output logic [OPCODE_WIDTH-1:0]              ex_opcode,
  output logic [OPERAND_WIDTH-1:0]             ex_operand0,
  output logic [OPERAND_WIDTH-1:0]             ex_operand1,
  output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] ex_dest,
  output logic                                 ex_writes
`ifdef ISSUE_STAGE_PERF_COUNTER_EN
  ,
  output logic [31:0]                          issued_count,
  output logic [31:0]                          stall_count
`endif
);

  issue_state_t                         state_q, state_d;
  logic [OPCODE_WIDTH-1:0]              opcode_q, opcode_d;
  logic [OPERAND_WIDTH-1:0]             operand0_q, operand0_d;
  logic [OPERAND_WIDTH-1:0]             operand1_q, operand1_d;
  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] dest_q, dest_d;
  logic                                 writes_q, writes_d;
  logic                                 issue;
  logic [OPERAND_WIDTH-1:0]             value0, value1;

  assign rf_operand0   = in_src0;
  assign rf_operand1   = in_src1;
  assign value0        = (in_src0 == '0) ? '0 : rf_value0;
  assign value1        = (in_src1 == '0) ? '0 : rf_value1;
  assign rf_write_back = wb_valid;
  assign rf_result     = wb_result;

  // The descriptor bus is shared with write-back, so issue waits while wb_valid is high.
  always_comb begin
    in_ready         = rst && !rf_reserved && !wb_valid && ((state_q == EMPTY) || ex_ready);
    issue            = in_valid && in_ready;
    rf_write_reserve = issue && in_writes && (in_dest != '0);
    rf_register      = wb_valid ? wb_register : in_dest;
    state_d          = state_q;
    opcode_d         = opcode_q;
    operand0_d       = operand0_q;
    operand1_d       = operand1_q;
    dest_d           = dest_q;
    writes_d         = writes_q;
    case (state_q)
      EMPTY:   if (issue) state_d = FULL;
      FULL:    if (ex_ready && !issue) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (issue) begin
      opcode_d   = in_opcode;
      operand0_d = value0;
      operand1_d = value1;
      dest_d     = in_dest;
      writes_d   = in_writes;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      opcode_q   <= '0;
      operand0_q <= '0;
      operand1_q <= '0;
      dest_q     <= '0;
      writes_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      operand0_q <= operand0_d;
      operand1_q <= operand1_d;
      dest_q     <= dest_d;
      writes_q   <= writes_d;
    end
  end

  assign ex_valid    = (state_q == FULL);
  assign ex_opcode   = opcode_q;
  assign ex_operand0 = operand0_q;
  assign ex_operand1 = operand1_q;
  assign ex_dest     = dest_q;
  assign ex_writes   = writes_q;

`ifdef ISSUE_STAGE_PERF_COUNTER_EN
  logic [31:0] issued_q, stall_q;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (issue) issued_q <= issued_q + 32'd1;
      if (in_valid && !in_ready) stall_q <= stall_q + 32'd1;
    end
  end

  assign issued_count = issued_q;
  assign stall_count  = stall_q;
`endif

endmodule

// File: tb/tb_issue_stage.sv
// Testbench for issue_stage: directed vector table, hand-written corner sequences and
// randomized traffic against a queue-based reference model.
module tb_issue_stage;
  import register_file_params::*;

  localparam int OW = 6;
  localparam int DW = REGISTER_DESCRIPTOR_WIDTH;
  localparam int VW = OPERAND_WIDTH;

  typedef struct packed {
    logic          inValid;
    logic [OW-1:0] opcode;
    logic [DW-1:0] src0;
    logic [VW-1:0] val0;
    logic [DW-1:0] src1;
    logic [VW-1:0] val1;
    logic [DW-1:0] dest;
    logic          writes;
    logic          reserved;
    logic          wbValid;
    logic [DW-1:0] wbReg;
    logic [VW-1:0] wbRes;
    logic          exReady;
  } drive_t;

  typedef struct packed {
    drive_t        d;
    logic          expReady;
    logic          expReserve;
    logic          expWb;
    logic          chkReg;
    logic [DW-1:0] expReg;
    logic          expExValid;
    logic [VW-1:0] expOp0;
    logic [VW-1:0] expOp1;
  } vec_t;

  typedef struct packed {
    logic [OW-1:0] opcode;
    logic [VW-1:0] op0;
    logic [VW-1:0] op1;
    logic [DW-1:0] dest;
    logic          writes;
  } instr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid, in_ready, in_writes;
  logic [OW-1:0] in_opcode;
  logic [DW-1:0] in_src0, in_src1, in_dest;
  logic [DW-1:0] rf_operand0, rf_operand1, rf_register, wb_register, ex_dest;
  logic [VW-1:0] rf_value0, rf_value1, rf_result, wb_result;
  logic          rf_reserved, rf_write_reserve, rf_write_back, wb_valid;
  logic          ex_valid, ex_ready, ex_writes;
  logic [OW-1:0] ex_opcode;
  logic [VW-1:0] ex_operand0, ex_operand1;
`ifdef ISSUE_STAGE_PERF_COUNTER_EN
  logic [31:0]   issued_count, stall_count;
`endif

  int            testsRun = 0;
  int            failCount = 0;
  drive_t        cur;
  instr_t        exq[$];
  logic [31:0]   issuedModel, stallModel;
  logic          modelReady, modelIssue;
  vec_t          vecs[8];

  issue_stage #(.OPCODE_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_src0(in_src0), .in_src1(in_src1), .in_dest(in_dest), .in_writes(in_writes),
    .rf_operand0(rf_operand0), .rf_operand1(rf_operand1),
    .rf_value0(rf_value0), .rf_value1(rf_value1), .rf_reserved(rf_reserved),
    .rf_write_reserve(rf_write_reserve), .rf_write_back(rf_write_back),
    .rf_register(rf_register), .rf_result(rf_result),
    .wb_valid(wb_valid), .wb_register(wb_register), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
    .ex_operand0(ex_operand0), .ex_operand1(ex_operand1),
    .ex_dest(ex_dest), .ex_writes(ex_writes)
`ifdef ISSUE_STAGE_PERF_COUNTER_EN
    , .issued_count(issued_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic drive_t mk(input logic iv, input logic [OW-1:0] op,
                                input logic [DW-1:0] s0, input logic [VW-1:0] v0,
                                input logic [DW-1:0] s1, input logic [VW-1:0] v1,
                                input logic [DW-1:0] ds, input logic wr, input logic rsv,
                                input logic wbv, input logic [DW-1:0] wbr,
                                input logic [VW-1:0] wbd, input logic exr);
    drive_t d;
    d.inValid = iv; d.opcode = op; d.src0 = s0; d.val0 = v0; d.src1 = s1; d.val1 = v1;
    d.dest = ds; d.writes = wr; d.reserved = rsv; d.wbValid = wbv; d.wbReg = wbr;
    d.wbRes = wbd; d.exReady = exr;
    return d;
  endfunction

  function automatic logic [VW-1:0] opnd(input logic [DW-1:0] s, input logic [VW-1:0] v);
    return (s == '0) ? '0 : v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input drive_t d);
    cur         = d;
    in_valid    = d.inValid;
    in_opcode   = d.opcode;
    in_src0     = d.src0;
    rf_value0   = d.val0;
    in_src1     = d.src1;
    rf_value1   = d.val1;
    in_dest     = d.dest;
    in_writes   = d.writes;
    rf_reserved = d.reserved;
    wb_valid    = d.wbValid;
    wb_register = d.wbReg;
    wb_result   = d.wbRes;
    ex_ready    = d.exReady;
  endtask

  // Reference: at most one instruction waits for execute; issue allowed when nothing blocks.
  task automatic checkOutput();
    logic expRes;
    modelReady = rst && !cur.reserved && !cur.wbValid && (exq.size() == 0 || cur.exReady);
    modelIssue = cur.inValid && modelReady;
    expRes     = modelIssue && cur.writes && (cur.dest != '0);
    cmp("in_ready", in_ready, modelReady);
    cmp("rf_operand0", rf_operand0, cur.src0);
    cmp("rf_operand1", rf_operand1, cur.src1);
    cmp("rf_write_reserve", rf_write_reserve, expRes);
    cmp("rf_write_back", rf_write_back, cur.wbValid);
    if (cur.wbValid) begin
      cmp("rf_register_wb", rf_register, cur.wbReg);
      cmp("rf_result", rf_result, cur.wbRes);
    end else if (expRes) begin
      cmp("rf_register_rsv", rf_register, cur.dest);
    end
    cmp("ex_valid", ex_valid, exq.size() != 0);
    if (exq.size() != 0) begin
      cmp("ex_opcode", ex_opcode, exq[0].opcode);
      cmp("ex_operand0", ex_operand0, exq[0].op0);
      cmp("ex_operand1", ex_operand1, exq[0].op1);
      cmp("ex_dest", ex_dest, exq[0].dest);
      cmp("ex_writes", ex_writes, exq[0].writes);
    end
`ifdef ISSUE_STAGE_PERF_COUNTER_EN
    cmp("issued_count", issued_count, issuedModel);
    cmp("stall_count", stall_count, stallModel);
`endif
  endtask

  task automatic advance();
    instr_t t;
    @(posedge clk);
    if (exq.size() != 0 && cur.exReady) void'(exq.pop_front());
    if (modelIssue) begin
      t.opcode = cur.opcode;
      t.op0    = opnd(cur.src0, cur.val0);
      t.op1    = opnd(cur.src1, cur.val1);
      t.dest   = cur.dest;
      t.writes = cur.writes;
      exq.push_back(t);
      issuedModel++;
    end
    if (cur.inValid && !modelReady) stallModel++;
    #1;
  endtask

  task automatic stepPre(input drive_t d);
    applyStimulus(d);
    #4;
    checkOutput();
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    #3;
    cmp("reset ex_valid", ex_valid, 1'b0);
    cmp("reset ex_opcode", ex_opcode, '0);
    cmp("reset ex_operand0", ex_operand0, '0);
    cmp("reset ex_operand1", ex_operand1, '0);
    cmp("reset ex_dest", ex_dest, '0);
    cmp("reset ex_writes", ex_writes, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exq.delete();
    issuedModel = '0;
    stallModel  = '0;
  endtask

  initial begin
    drive_t idle, rd;
    issuedModel = '0;
    stallModel  = '0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    vecs[0] = '{mk(1, 6'h01, 3, 32'h11, 0, 32'h99, 5, 1, 0, 0, 0, 0, 1), 1, 1, 0, 1, 5, 0, 0, 0};
    vecs[1] = '{idle, 1, 0, 0, 0, 0, 1, 32'h11, 32'h0};
    vecs[2] = '{mk(1, 6'h02, 2, 32'h22, 4, 32'h44, 6, 1, 0, 1, 7, 32'h77, 1), 0, 0, 1, 1, 7, 0, 0, 0};
    vecs[3] = '{mk(1, 6'h02, 2, 32'h22, 4, 32'h44, 6, 1, 0, 0, 0, 0, 1), 1, 1, 0, 1, 6, 0, 0, 0};
    vecs[4] = '{mk(1, 6'h03, 0, 32'h55, 1, 32'h33, 0, 1, 0, 0, 0, 0, 1), 1, 0, 0, 0, 0, 1, 32'h22, 32'h44};
    vecs[5] = '{idle, 1, 0, 0, 0, 0, 1, 32'h0, 32'h33};
    vecs[6] = '{mk(1, 6'h04, 1, 1, 1, 1, 12, 1, 1, 0, 0, 0, 1), 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{idle, 1, 0, 0, 0, 0, 0, 0, 0};

    doReset();

    for (int i = 0; i < 8; i++) begin
      stepPre(vecs[i].d);
      cmp($sformatf("v%0d in_ready", i), in_ready, vecs[i].expReady);
      cmp($sformatf("v%0d reserve", i), rf_write_reserve, vecs[i].expReserve);
      cmp($sformatf("v%0d write_back", i), rf_write_back, vecs[i].expWb);
      if (vecs[i].chkReg) cmp($sformatf("v%0d rf_register", i), rf_register, vecs[i].expReg);
      cmp($sformatf("v%0d ex_valid", i), ex_valid, vecs[i].expExValid);
      if (vecs[i].expExValid) begin
        cmp($sformatf("v%0d ex_operand0", i), ex_operand0, vecs[i].expOp0);
        cmp($sformatf("v%0d ex_operand1", i), ex_operand1, vecs[i].expOp1);
      end
      advance();
    end

    // Reservation held three cycles, then write-back of r5, then issue.
    rd = mk(1, 6'h05, 5, 32'h5A, 0, 0, 8, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      stepPre(rd);
      cmp($sformatf("hazard c%0d in_ready", i), in_ready, 1'b0);
      advance();
    end
    rd.reserved = 1'b0; rd.wbValid = 1'b1; rd.wbReg = 5; rd.wbRes = 32'h5A;
    stepPre(rd);
    cmp("hazard wb in_ready", in_ready, 1'b0);
    cmp("hazard wb rf_register", rf_register, 5);
    advance();
    rd.wbValid = 1'b0;
    stepPre(rd);
    cmp("hazard issue in_ready", in_ready, 1'b1);
    cmp("hazard issue reserve", rf_write_reserve, 1'b1);
    cmp("hazard issue rf_register", rf_register, 8);
    advance();
    stepPre(idle);
    cmp("hazard ex_dest", ex_dest, 8);
    cmp("hazard ex_operand0", ex_operand0, 32'h5A);
    advance();

    // Execute backpressure with a second instruction waiting.
    stepPre(mk(1, 6'h0A, 1, 32'hA1, 2, 32'hA2, 10, 1, 0, 0, 0, 0, 0));
    advance();
    for (int i = 0; i < 2; i++) begin
      stepPre(mk(1, 6'h0B, 3, 32'hB1, 4, 32'hB2, 11, 1, 0, 0, 0, 0, 0));
      cmp($sformatf("stall c%0d in_ready", i), in_ready, 1'b0);
      cmp($sformatf("stall c%0d ex_opcode", i), ex_opcode, 6'h0A);
      cmp($sformatf("stall c%0d ex_operand0", i), ex_operand0, 32'hA1);
      advance();
    end
    stepPre(mk(1, 6'h0B, 3, 32'hB1, 4, 32'hB2, 11, 1, 0, 0, 0, 0, 1));
    cmp("stall release in_ready", in_ready, 1'b1);
    cmp("stall release ex_opcode", ex_opcode, 6'h0A);
    advance();
    stepPre(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cmp("b2b ex_valid", ex_valid, 1'b1);
    cmp("b2b ex_opcode", ex_opcode, 6'h0B);
    advance();
    stepPre(idle);
    advance();

    // Asynchronous reset while FULL.
    stepPre(mk(1, 6'h0C, 2, 32'hC2, 0, 0, 9, 1, 0, 0, 0, 0, 0));
    advance();
    applyStimulus(mk(1, 6'h0D, 1, 32'hD1, 0, 0, 9, 1, 0, 0, 0, 0, 0));
    #1;
    rst = 1'b0;
    #1;
    cmp("async ex_valid", ex_valid, 1'b0);
    cmp("async ex_opcode", ex_opcode, '0);
    cmp("async ex_operand0", ex_operand0, '0);
    cmp("async ex_dest", ex_dest, '0);
    cmp("async ex_writes", ex_writes, 1'b0);
    cmp("async in_ready", in_ready, 1'b0);
    cmp("async reserve", rf_write_reserve, 1'b0);
`ifdef ISSUE_STAGE_PERF_COUNTER_EN
    cmp("async issued_count", issued_count, 32'd0);
    cmp("async stall_count", stall_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    cmp("async held ex_valid", ex_valid, 1'b0);
    rst = 1'b1;
    exq.delete();
    issuedModel = '0;
    stallModel  = '0;

    for (int n = 0; n < 400; n++) begin
      drive_t r;
      r.inValid  = ($urandom_range(0, 9) < 7);
      r.opcode   = OW'($urandom);
      r.src0     = ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom_range(1, REGISTER_SIZE - 1));
      r.val0     = $urandom;
      r.src1     = ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom_range(1, REGISTER_SIZE - 1));
      r.val1     = $urandom;
      r.dest     = ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom_range(1, REGISTER_SIZE - 1));
      r.writes   = $urandom_range(0, 1) == 1;
      r.reserved = ($urandom_range(0, 9) < 2);
      r.wbValid  = ($urandom_range(0, 9) < 2);
      r.wbReg    = DW'($urandom);
      r.wbRes    = $urandom;
      r.exReady  = ($urandom_range(0, 9) < 7);
      stepPre(r);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
